axis_scale_sat: RTL and testbench
=================================

Name: axis_scale_sat

Overview:
- Multi-lane AXI-Stream scaler that converts wide fixed-point data, such as 32-bit PIG output, to narrow DAC words.
- Shift amount is set at runtime, with optional round-half-up and optional saturation; the default is wrap.
- A 2-stage registered pipeline with full valid/ready handshake and per-lane sticky out-of-range flags.
- Sits between the PIG/filter chain and the DAC interface, one instance per DAC pair.

Parameters:
NUM_CH, 2, lane count packed in each beat (lane 0 in LSBs)
IN_W, 32, input lane width
OUT_W, 14, significant output bits per lane (DAC width)
OUT_LANE_W, 16, output lane field width; must be >= OUT_W
SHIFT_W, 6, width of shift_cfg
SIGNED, 1, 1 = two's-complement lanes; 0 = unsigned lanes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
shift_cfg  in  SHIFT_W  right-shift amount applied to each lane
round_en  in  1  1 = round half-up before the shift
sat_en  in  1  1 = saturate out-of-range results; 0 = wrap
sat_clr  in  1  clears sat_flag
sat_flag  out  NUM_CH  sticky per-lane out-of-range indicator
S_AXIS_RAW_tdata  in  NUM_CH*IN_W  input lanes
S_AXIS_RAW_tvalid  in  1  input valid
S_AXIS_RAW_tready  out  1  input ready
M_AXIS_SCALED_tdata  out  NUM_CH*OUT_LANE_W  output lanes
M_AXIS_SCALED_tvalid  out  1  output valid
M_AXIS_SCALED_tready  in  1  downstream ready

Behaviour:
- Interface: clock is clk; reset is rst, synchronous, active-high. Only the clk and rst names are fixed here.
- Reset state: stage-1 and stage-2 valid = 0; M_AXIS_SCALED_tdata = 0; M_AXIS_SCALED_tvalid = 0; sat_flag = 0.
- Reset mid-stream drops all in-flight beats. No output beat appears on the cycle after rst deasserts.
- Pipeline advance: ce = !M_AXIS_SCALED_tvalid || M_AXIS_SCALED_tready.
  - S_AXIS_RAW_tready = ce; this is a combinational path, and it is accepted.
  - A beat is accepted when S_AXIS_RAW_tvalid && ce.
  - Latency: 2 clk from acceptance to M_AXIS_SCALED_tvalid.
  - Throughput: 1 beat/clk while tready stays high.
  - No beat is lost, duplicated or reordered.
  - While M_AXIS_SCALED_tvalid is high and tready is low, M_AXIS_SCALED_tdata holds stable.
- Stage 1 (register on ce):
  - shift_cfg, round_en and sat_en are sampled with the beat; later config changes do not affect beats already in flight.
  - Effective shift s = min(shift_cfg, IN_W-1).
  - Rounding: if round_en && s > 0, add 2^(s-1) in IN_W+1 bits (sign- or zero-extended per SIGNED), so the add cannot overflow.
  - Shift right by s: arithmetic if SIGNED, logical otherwise. The result is held at IN_W+1 bits.
- Stage 2 (register on ce): range check against OUT_W.
  - SIGNED limits: [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Unsigned limits: [0, 2^OUT_W-1].
  - Out of range with sat_en = 1: clamp to the nearest limit.
  - Out of range with sat_en = 0: keep the low OUT_W bits (wrap).
- Output lane format: the OUT_W result is right-aligned in its OUT_LANE_W field. Upper bits are sign-extended if SIGNED, zero-filled otherwise.
- sat_flag[i]:
  - Set when lane i is out of range in a beat advancing stage 1 to stage 2, whatever sat_en is.
  - Cleared by sat_clr. If set and clear occur in the same cycle, set wins.
- Lanes are processed independently with identical config.

Test Plan:
- Signed, shift 18, round off, sat on:
  - in lane 0x7FFFFFFF -> 0x1FFF, flag 0.
  - in lane 0x80000000 -> 0xE000 (sign-extended -8192), flag 0.
  - 2 clk latency checked.
- Same config with round_en = 1, in 0x7FFFFFFF: rounded value 8192 -> saturates to 0x1FFF; sat_flag set and stays set until sat_clr; sat_clr pulsed together with a new overflow -> flag stays 1.
- Shift 10, in 0x01000000 (value 16384):
  - sat on -> 0x1FFF.
  - sat off -> 0x0000 (wrap).
  - flag set in both cases.
  - Lane 1 = 0x00100000 in the same beat -> 0x0400, flag[1] = 0.
- Rounding, shift 4:
  - in 24, round on -> 2; round off -> 1.
  - in -24 (0xFFFFFFE8), round on -> -1 (0xFFFF); round off -> -2 (0xFFFE).
- Backpressure: stream 8 incrementing beats with M_AXIS_SCALED_tready low for 3 cycles mid-stream.
  - S_AXIS_RAW_tready drops.
  - Output tdata is stable while stalled.
  - All 8 beats arrive in order with no duplicates.
  - shift_cfg changed during the stall -> beats already in flight are unaffected.
- rst asserted for 1 cycle with 2 beats in flight -> M_AXIS_SCALED_tvalid = 0, tdata = 0, sat_flag = 0 next cycle; the stream resumes cleanly afterwards.

Source files
------------

// File: rtl/axis_scale_sat.sv
// axis_scale_sat: multi-lane AXI-Stream scaler from wide fixed-point lanes to
// narrow DAC words. Two registered stages share a single advance enable:
//   stage 1: capture config, optional round-half-up, right shift (IN_W+1 bits)
//   stage 2: range check against OUT_W, saturate or wrap, lane formatting
// Per-lane sticky flags record any out-of-range lane regardless of sat_en.
module axis_scale_sat #(
  parameter int NUM_CH     = 2,
  parameter int IN_W       = 32,
  parameter int OUT_W      = 14,
  parameter int OUT_LANE_W = 16,
  parameter int SHIFT_W    = 6,
  parameter int SIGNED     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SHIFT_W-1:0]           shift_cfg,
  input  logic                         round_en,
  input  logic                         sat_en,
  input  logic                         sat_clr,
  output logic [NUM_CH-1:0]            sat_flag,
  input  logic [NUM_CH*IN_W-1:0]       S_AXIS_RAW_tdata,
  input  logic                         S_AXIS_RAW_tvalid,
  output logic                         S_AXIS_RAW_tready,
  output logic [NUM_CH*OUT_LANE_W-1:0] M_AXIS_SCALED_tdata,
  output logic                         M_AXIS_SCALED_tvalid,
  input  logic                         M_AXIS_SCALED_tready
);

  // Stage-1 lanes carry one extra bit so the rounding add cannot overflow.
  localparam int EXT_W = IN_W + 1;
  localparam int SH_W  = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam logic [EXT_W-1:0] ONE_EXT = {{(EXT_W-1){1'b0}}, 1'b1};
  localparam logic [SH_W-1:0]  ONE_SH  = {{(SH_W-1){1'b0}}, 1'b1};

  // Clamp the runtime shift to IN_W-1; larger requests would discard everything.
  function automatic logic [SH_W-1:0] eff_shift(input logic [SHIFT_W-1:0] cfg);
    logic [31:0] cfg_w;
    cfg_w = 32'(cfg);
    if (cfg_w > 32'(IN_W - 1)) begin
      eff_shift = SH_W'(IN_W - 1);
    end else begin
      eff_shift = cfg_w[SH_W-1:0];
    end
  endfunction

  // Extend, optionally add half an LSB of the shifted result, then shift.
  function automatic logic [EXT_W-1:0] scale_lane(input logic [IN_W-1:0] x,
                                                  input logic [SH_W-1:0] s,
                                                  input logic            rnd);
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] bias;
    logic [EXT_W-1:0] sum;
    if (SIGNED != 0) begin
      ext = {x[IN_W-1], x};
    end else begin
      ext = {1'b0, x};
    end
    if (rnd && (s != {SH_W{1'b0}})) begin
      bias = ONE_EXT << (s - ONE_SH);
    end else begin
      bias = {EXT_W{1'b0}};
    end
    sum = ext + bias;
    if (SIGNED != 0) begin
      scale_lane = $unsigned($signed(sum) >>> s);
    end else begin
      scale_lane = sum >> s;
    end
  endfunction

  // A value fits OUT_W bits when every bit above the kept field matches the
  // sign bit (signed) or is zero (unsigned).
  function automatic logic lane_oor(input logic [EXT_W-1:0] v);
    if (SIGNED != 0) begin
      lane_oor = !((&v[EXT_W-1:OUT_W-1]) || !(|v[EXT_W-1:OUT_W-1]));
    end else begin
      lane_oor = |v[EXT_W-1:OUT_W];
    end
  endfunction

  // Clamp to the nearest limit or keep the low OUT_W bits.
  function automatic logic [OUT_W-1:0] lane_result(input logic [EXT_W-1:0] v,
                                                   input logic            sat);
    logic [OUT_W-1:0] res;
    if (sat && lane_oor(v)) begin
      if (SIGNED != 0) begin
        res = v[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        res = {OUT_W{1'b1}};
      end
    end else begin
      res = v[OUT_W-1:0];
    end
    lane_result = res;
  endfunction

  // Right-align the result in its output field with sign or zero fill.
  function automatic logic [OUT_LANE_W-1:0] lane_field(input logic [OUT_W-1:0] r);
    if (SIGNED != 0) begin
      lane_field = OUT_LANE_W'($signed(r));
    end else begin
      lane_field = OUT_LANE_W'(r);
    end
  endfunction

  logic                              ce;
  logic                              s1_valid_q, s1_valid_d;
  logic                              s1_sat_en_q, s1_sat_en_d;
  logic [NUM_CH-1:0][EXT_W-1:0]      s1_data_q, s1_data_d;
  logic                              m_valid_q, m_valid_d;
  logic [NUM_CH*OUT_LANE_W-1:0]      m_data_q, m_data_d;
  logic [NUM_CH-1:0]                 flag_q, flag_d;
  logic [NUM_CH-1:0]                 flag_set;
  logic [SH_W-1:0]                   shift_s;

  // The whole pipeline moves together whenever the output slot is free.
  assign ce                   = !m_valid_q || M_AXIS_SCALED_tready;
  assign S_AXIS_RAW_tready    = ce;
  assign M_AXIS_SCALED_tdata  = m_data_q;
  assign M_AXIS_SCALED_tvalid = m_valid_q;
  assign sat_flag             = flag_q;

  // Next-state for both stages and the sticky flags.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sat_en_d = s1_sat_en_q;
    s1_data_d   = s1_data_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    flag_set    = {NUM_CH{1'b0}};
    shift_s     = eff_shift(shift_cfg);

    if (ce) begin
      s1_valid_d = S_AXIS_RAW_tvalid;
      if (S_AXIS_RAW_tvalid) begin
        s1_sat_en_d = sat_en;
        for (int i = 0; i < NUM_CH; i++) begin
          s1_data_d[i] = scale_lane(S_AXIS_RAW_tdata[i*IN_W +: IN_W], shift_s, round_en);
        end
      end else begin
        s1_sat_en_d = s1_sat_en_q;
      end

      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_data_d[i*OUT_LANE_W +: OUT_LANE_W] = lane_field(lane_result(s1_data_q[i], s1_sat_en_q));
          flag_set[i] = lane_oor(s1_data_q[i]);
        end
      end else begin
        m_data_d = m_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
      m_valid_d  = m_valid_q;
    end

    // A new out-of-range lane overrides a simultaneous clear.
    if (sat_clr) begin
      flag_d = flag_set;
    end else begin
      flag_d = flag_q | flag_set;
    end
  end

  // Pipeline and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sat_en_q <= 1'b0;
      s1_data_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= {(NUM_CH*OUT_LANE_W){1'b0}};
      flag_q      <= {NUM_CH{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sat_en_q <= s1_sat_en_d;
      s1_data_q   <= s1_data_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      flag_q      <= flag_d;
    end
  end

endmodule

// File: tb/tb_axis_scale_sat.sv
// Testbench for axis_scale_sat (default parameters: 2 signed lanes, 32 -> 14 bits
// in 16-bit fields). Directed vector table, hand-written corner sequences and a
// randomized stream checked against an integer-arithmetic reference model.
module tb_axis_scale_sat;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  shift_cfg;
  logic        round_en;
  logic        sat_en;
  logic        sat_clr;
  logic [1:0]  sat_flag;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  int n_checks = 0;
  int n_errors = 0;

  axis_scale_sat dut (
    .clk                  (clk),
    .rst                  (rst),
    .shift_cfg            (shift_cfg),
    .round_en             (round_en),
    .sat_en               (sat_en),
    .sat_clr              (sat_clr),
    .sat_flag             (sat_flag),
    .S_AXIS_RAW_tdata     (s_tdata),
    .S_AXIS_RAW_tvalid    (s_tvalid),
    .S_AXIS_RAW_tready    (s_tready),
    .M_AXIS_SCALED_tdata  (m_tdata),
    .M_AXIS_SCALED_tvalid (m_tvalid),
    .M_AXIS_SCALED_tready (m_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] l0;
    logic [31:0] l1;
    int          sh;
    bit          rnd;
    bit          sat;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  ef;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the signed lane value.
  function automatic logic [15:0] ref_lane(input logic [31:0] x, input int sh,
                                           input bit rnd, input bit sat, output bit oor);
    longint v;
    longint w;
    int     s;
    v = longint'($signed(x));
    s = (sh > 31) ? 31 : sh;
    if (rnd && s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    oor = (v > 8191) || (v < -8192);
    if (oor && sat) w = (v > 0) ? 8191 : -8192;
    else begin
      w = v & 64'h3FFF;
      if (w >= 8192) w = w - 16384;
    end
    return w[15:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [63:0] d, input int sh,
                                           input bit rnd, input bit sat);
    bit o0, o1;
    logic [15:0] r0, r1;
    r0 = ref_lane(d[31:0], sh, rnd, sat, o0);
    r1 = ref_lane(d[63:32], sh, rnd, sat, o1);
    return {r1, r0};
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] b[4];
    b[0] = 32'h7FFFFFFF; b[1] = 32'h80000000; b[2] = 32'h00000000; b[3] = 32'hFFFFFFFF;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 40000));
      2: return -32'($urandom_range(0, 40000));
      default: return b[$urandom_range(0, 3)];
    endcase
  endfunction

  // One beat through an idle pipeline: latency, data, flags, then clear.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    s_tdata   = {v.l1, v.l0};
    shift_cfg = 6'(v.sh);
    round_en  = v.rnd;
    sat_en    = v.sat;
    s_tvalid  = 1'b1;
    m_tready  = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(m_tvalid), 32'd0);
    step();
    chk({tag, "_lat2_valid"}, 32'(m_tvalid), 32'd1);
    chk({tag, "_lane0"}, 32'(m_tdata[15:0]), 32'(v.e0));
    chk({tag, "_lane1"}, 32'(m_tdata[31:16]), 32'(v.e1));
    chk({tag, "_flag"}, 32'(sat_flag), 32'(v.ef));
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk({tag, "_flag_clr"}, 32'(sat_flag), 32'd0);
  endtask

  // Streaming with scoreboard; mode 0 = directed backpressure, 1 = random.
  task automatic stream(input int n_beats, input bit rand_mode);
    logic [31:0] exp_q[$];
    logic [31:0] held;
    logic [63:0] d;
    int  sent = 0;
    int  recv = 0;
    int  blocked = 0;
    bit  pending = 0;
    bit  was_stalled = 0;
    held = 32'd0;
    for (int cyc = 0; cyc < n_beats * 8 + 50 && recv < n_beats; cyc++) begin
      if (rand_mode) m_tready = ($urandom_range(0, 9) < 7);
      else           m_tready = !(cyc >= 4 && cyc <= 6);
      if (!pending) begin
        if (sent < n_beats && (!rand_mode || $urandom_range(0, 3) != 0)) begin
          if (rand_mode) begin
            s_tdata   = {rnd_word(), rnd_word()};
            shift_cfg = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(10, 20))
                                                    : 6'($urandom_range(0, 63));
            round_en  = 1'($urandom_range(0, 1));
            sat_en    = 1'($urandom_range(0, 1));
          end else begin
            d[31:0]  = 32'(sent + 1) << 10;
            d[63:32] = -(32'(sent + 1) << 10);
            s_tdata  = d;
          end
          s_tvalid = 1'b1;
          pending  = 1'b1;
        end else begin
          s_tvalid = 1'b0;
        end
      end
      if (!rand_mode && cyc == 5) shift_cfg = 6'd2;
      #1;
      chk("s_tready", 32'(s_tready), 32'(!m_tvalid || m_tready));
      if (!s_tready) blocked++;
      if (was_stalled) chk("stall_hold", m_tdata, held);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", m_tdata, 32'hXXXXXXXX);
        else chk($sformatf("beat%0d", recv), m_tdata, exp_q.pop_front());
        recv++;
      end
      was_stalled = m_tvalid && !m_tready;
      held = m_tdata;
      if (s_tvalid && s_tready) begin
        exp_q.push_back(ref_word(s_tdata, int'(shift_cfg), round_en, sat_en));
        sent++;
        pending = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    chk("drain_count", 32'(recv), 32'(n_beats));
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    if (!rand_mode) chk("tready_drop_seen", 32'(blocked > 0), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h7FFFFFFF, 32'h80000000, 18, 1'b0, 1'b1, 16'h1FFF, 16'hE000, 2'b00};
    vecs[1] = '{32'h7FFFFFFF, 32'h80000000, 18, 1'b1, 1'b1, 16'h1FFF, 16'hE000, 2'b01};
    vecs[2] = '{32'h01000000, 32'h00100000, 10, 1'b0, 1'b1, 16'h1FFF, 16'h0400, 2'b01};
    vecs[3] = '{32'h01000000, 32'h00100000, 10, 1'b0, 1'b0, 16'h0000, 16'h0400, 2'b01};
    vecs[4] = '{32'h00000018, 32'hFFFFFFE8, 4,  1'b1, 1'b1, 16'h0002, 16'hFFFF, 2'b00};
    vecs[5] = '{32'h00000018, 32'hFFFFFFE8, 4,  1'b0, 1'b1, 16'h0001, 16'hFFFE, 2'b00};
    vecs[6] = '{32'h80000000, 32'h7FFFFFFF, 63, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 2'b00};
    vecs[7] = '{32'h00002000, 32'hFFFFE000, 0,  1'b0, 1'b0, 16'hE000, 16'hE000, 2'b01};
    vecs[8] = '{32'hFFFFDFFF, 32'h00001FFF, 0,  1'b0, 1'b1, 16'hE000, 16'h1FFF, 2'b01};

    rst = 1'b1; shift_cfg = 6'd0; round_en = 1'b0; sat_en = 1'b0; sat_clr = 1'b0;
    s_tdata = 64'd0; s_tvalid = 1'b0; m_tready = 1'b1;
    step(); step(); step();
    chk("rst_valid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_flag", 32'(sat_flag), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(m_tvalid), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Sticky flag, then clear and set in the same cycle: set wins.
    s_tdata = {32'h00000000, 32'h7FFFFFFF};
    shift_cfg = 6'd18; round_en = 1'b1; sat_en = 1'b1;
    s_tvalid = 1'b1; step(); s_tvalid = 1'b0; step();
    chk("sticky_set", 32'(sat_flag), 32'd1);
    step(); step(); step();
    chk("sticky_hold", 32'(sat_flag), 32'd1);
    s_tvalid = 1'b1; step(); s_tvalid = 1'b0;
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    chk("set_wins_flag", 32'(sat_flag), 32'd1);
    chk("set_wins_data", m_tdata, {16'h0000, 16'h1FFF});
    step();
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    chk("clr_after", 32'(sat_flag), 32'd0);

    // Reset with two beats in flight (output stalled).
    m_tready = 1'b0; shift_cfg = 6'd10; round_en = 1'b0; sat_en = 1'b1;
    s_tdata = {32'h00100000, 32'h01000000}; s_tvalid = 1'b1; step();
    s_tdata = {32'h00000000, 32'h00000400}; step();
    s_tvalid = 1'b0;
    chk("pre_rst_valid", 32'(m_tvalid), 32'd1);
    chk("pre_rst_flag", 32'(sat_flag), 32'd1);
    chk("pre_rst_stall_ready", 32'(s_tready), 32'd0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_valid", 32'(m_tvalid), 32'd0);
    chk("midrst_tdata", m_tdata, 32'd0);
    chk("midrst_flag", 32'(sat_flag), 32'd0);
    m_tready = 1'b1;
    step();
    chk("no_ghost_1", 32'(m_tvalid), 32'd0);
    step();
    chk("no_ghost_2", 32'(m_tvalid), 32'd0);
    run_vec(100, vecs[2]);

    // Backpressure with a config change during the stall.
    shift_cfg = 6'd10; round_en = 1'b0; sat_en = 1'b1;
    stream(8, 1'b0);

    // Randomized stream against the reference model.
    stream(200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
